// File: rtl/data_mem_unit.sv
// Multi-cycle data-memory responder: word storage behind a MemRead/MemWrite handshake,
// stalling the datapath for LATENCY cycles and flagging misaligned or out-of-range requests.
module data_mem_unit #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 64,
   parameter int unsigned LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic [31:0]           Address,
   input  logic [DATA_WIDTH-1:0] WriteData,
   output logic [DATA_WIDTH-1:0] ReadData,
   output logic                  Stall,
   output logic                  Ready,
   output logic                  AddrError
);

   localparam int unsigned IdxW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(LATENCY + 1);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e                stateQ, stateD;
   logic [CntW-1:0]       cntQ, cntD;
   logic [IdxW-1:0]       idxQ;
   logic [DATA_WIDTH-1:0] wdataQ;
   logic                  isReadQ;
   logic                  rejQ;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  req;
   logic                  reqBad;
   logic                  commit;
   logic                  zeroRead;
   logic [IdxW-1:0]       comIdx;
   logic                  comRead;
   logic [DATA_WIDTH-1:0] comData;

   always_comb begin
      req      = MemRead | MemWrite;
      reqBad   = (Address[1:0] != 2'b00) || (|Address[31:IdxW+2]) || (MemRead && MemWrite);
      stateD   = stateQ;
      cntD     = cntQ;
      Stall    = 1'b0;
      Ready    = 1'b0;
      AddrError = 1'b0;
      commit   = 1'b0;
      zeroRead = 1'b0;
      comIdx   = idxQ;
      comRead  = isReadQ;
      comData  = wdataQ;
      unique case (stateQ)
         StIdle: begin
            Stall = req;
            if (req) begin
               if (reqBad) begin
                  stateD   = StDone;
                  zeroRead = MemRead;
               end else if (LATENCY == 1) begin
                  // Single-cycle access commits straight from the live inputs.
                  stateD  = StDone;
                  commit  = 1'b1;
                  comIdx  = Address[IdxW+1:2];
                  comRead = MemRead;
                  comData = WriteData;
               end else begin
                  stateD = StBusy;
                  cntD   = CntW'(LATENCY - 1);
               end
            end
         end
         StBusy: begin
            Stall = 1'b1;
            cntD  = cntQ - CntW'(1);
            if (cntQ == CntW'(1)) begin
               stateD = StDone;
               commit = 1'b1;
            end
         end
         StDone: begin
            Ready     = ~reset;
            AddrError = rejQ & ~reset;
            stateD    = StIdle;
         end
         default: stateD = StIdle;
      endcase
      // Reset wins over any commit or rejection in the same cycle.
      if (reset) begin
         stateD   = StIdle;
         cntD     = '0;
         commit   = 1'b0;
         zeroRead = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stateQ   <= StIdle;
         cntQ     <= '0;
         rejQ     <= 1'b0;
         ReadData <= '0;
      end else begin
         stateQ <= stateD;
         cntQ   <= cntD;
         if (stateQ == StIdle && req) begin
            rejQ <= reqBad;
         end
         if (commit && comRead) begin
            ReadData <= mem[comIdx];
         end else if (zeroRead) begin
            ReadData <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (stateQ == StIdle && req) begin
         idxQ    <= Address[IdxW+1:2];
         wdataQ  <= WriteData;
         isReadQ <= MemRead;
      end
   end

   always_ff @(posedge clk) begin
      if (commit && !comRead) begin
         mem[comIdx] <= comData;
      end
   end

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: one instance at LATENCY=2 and one at LATENCY=3
// sharing clock and reset, with separate request inputs.
module tb_data_mem_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemRead2, MemWrite2, MemRead3, MemWrite3;
   logic [31:0] Address2, WriteData2, Address3, WriteData3;
   logic [31:0] ReadData2, ReadData3;
   logic        Stall2, Ready2, AddrError2, Stall3, Ready3, AddrError3;

   int nChecks = 0;
   int nFail   = 0;

   always #5 clk = ~clk;

   data_mem_unit #(.DATA_WIDTH(32), .DEPTH(64), .LATENCY(2)) dut2 (
      .clk(clk), .reset(reset), .MemRead(MemRead2), .MemWrite(MemWrite2),
      .Address(Address2), .WriteData(WriteData2), .ReadData(ReadData2),
      .Stall(Stall2), .Ready(Ready2), .AddrError(AddrError2)
   );

   data_mem_unit #(.DATA_WIDTH(32), .DEPTH(64), .LATENCY(3)) dut3 (
      .clk(clk), .reset(reset), .MemRead(MemRead3), .MemWrite(MemWrite3),
      .Address(Address3), .WriteData(WriteData3), .ReadData(ReadData3),
      .Stall(Stall3), .Ready(Ready3), .AddrError(AddrError3)
   );

   // Issues one request for a single cycle and measures the response; no checking here.
   task automatic access(input bit u3, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, output int cycles, output int stalls,
                         output logic err, output logic [31:0] rdata, output bit ok);
      ok = 1'b0; cycles = 0; stalls = 0; err = 1'b0; rdata = '0;
      @(negedge clk);
      if (u3) begin
         MemRead3 = rd; MemWrite3 = wr; Address3 = a; WriteData3 = d;
      end else begin
         MemRead2 = rd; MemWrite2 = wr; Address2 = a; WriteData2 = d;
      end
      for (int i = 0; i < 16; i++) begin
         #1;
         if (u3 ? Ready3 : Ready2) begin
            ok     = 1'b1;
            cycles = i;
            err    = u3 ? AddrError3 : AddrError2;
            rdata  = u3 ? ReadData3 : ReadData2;
            break;
         end
         if (u3 ? Stall3 : Stall2) stalls++;
         @(negedge clk);
         MemRead2 = 1'b0; MemWrite2 = 1'b0; MemRead3 = 1'b0; MemWrite3 = 1'b0;
      end
      MemRead2 = 1'b0; MemWrite2 = 1'b0; MemRead3 = 1'b0; MemWrite3 = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      MemRead2 = 1'b0; MemWrite2 = 1'b0; Address2 = '0; WriteData2 = '0;
      MemRead3 = 1'b0; MemWrite3 = 1'b0; Address3 = '0; WriteData3 = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk); #1;
      nChecks++; if (Stall2 !== 1'b0) begin nFail++; $display("FAIL reset_stall got=%b exp=0", Stall2); end
      nChecks++; if (Ready2 !== 1'b0) begin nFail++; $display("FAIL reset_ready got=%b exp=0", Ready2); end
      nChecks++; if (AddrError2 !== 1'b0) begin nFail++; $display("FAIL reset_adderr got=%b exp=0", AddrError2); end
      nChecks++; if (ReadData2 !== 32'h0) begin nFail++; $display("FAIL reset_rdata got=%h exp=0", ReadData2); end
      nChecks++; if (ReadData3 !== 32'h0) begin nFail++; $display("FAIL reset_rdata3 got=%h exp=0", ReadData3); end
   endtask

   task automatic test_write_read;
      int cyc, st; logic err; logic [31:0] rd; bit ok;
      access(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, cyc, st, err, rd, ok);
      nChecks++; if (!ok) begin nFail++; $display("FAIL wr_timeout got=none exp=Ready"); end
      nChecks++; if (st !== 2) begin nFail++; $display("FAIL wr_stalls got=%0d exp=2", st); end
      nChecks++; if (cyc !== 2) begin nFail++; $display("FAIL wr_latency got=%0d exp=2", cyc); end
      nChecks++; if (Stall2 !== 1'b0) begin nFail++; $display("FAIL wr_done_stall got=%b exp=0", Stall2); end
      nChecks++; if (err !== 1'b0) begin nFail++; $display("FAIL wr_adderr got=%b exp=0", err); end
      nChecks++; if (rd !== 32'h0) begin nFail++; $display("FAIL wr_rdata_held got=%h exp=0", rd); end
      @(negedge clk); #1;
      nChecks++; if (Ready2 !== 1'b0) begin nFail++; $display("FAIL wr_ready_pulse got=%b exp=0", Ready2); end
      access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, cyc, st, err, rd, ok);
      nChecks++; if (!ok) begin nFail++; $display("FAIL rd_timeout got=none exp=Ready"); end
      nChecks++; if (st !== 2) begin nFail++; $display("FAIL rd_stalls got=%0d exp=2", st); end
      nChecks++; if (rd !== 32'hDEADBEEF) begin nFail++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
   endtask

   task automatic test_misaligned;
      int cyc, st; logic err; logic [31:0] rd; bit ok;
      access(1'b0, 1'b1, 1'b0, 32'h13, 32'h0, cyc, st, err, rd, ok);
      nChecks++; if (!ok) begin nFail++; $display("FAIL mis_timeout got=none exp=Ready"); end
      nChecks++; if (st !== 1) begin nFail++; $display("FAIL mis_stalls got=%0d exp=1", st); end
      nChecks++; if (cyc !== 1) begin nFail++; $display("FAIL mis_latency got=%0d exp=1", cyc); end
      nChecks++; if (err !== 1'b1) begin nFail++; $display("FAIL mis_adderr got=%b exp=1", err); end
      nChecks++; if (rd !== 32'h0) begin nFail++; $display("FAIL mis_rdata got=%h exp=0", rd); end
      access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, cyc, st, err, rd, ok);
      nChecks++; if (rd !== 32'hDEADBEEF) begin nFail++; $display("FAIL mis_after got=%h exp=deadbeef", rd); end
   endtask

   task automatic test_range_conflict;
      int cyc, st; logic err; logic [31:0] rd; bit ok;
      access(1'b0, 1'b0, 1'b1, 32'h0, 32'h11112222, cyc, st, err, rd, ok);
      access(1'b0, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, cyc, st, err, rd, ok);
      access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, cyc, st, err, rd, ok);
      // 0x100 aliases word 0 if the range check were missing.
      access(1'b0, 1'b0, 1'b1, 32'h100, 32'hBADBAD00, cyc, st, err, rd, ok);
      nChecks++; if (err !== 1'b1) begin nFail++; $display("FAIL oor_adderr got=%b exp=1", err); end
      nChecks++; if (st !== 1) begin nFail++; $display("FAIL oor_stalls got=%0d exp=1", st); end
      nChecks++; if (rd !== 32'hDEADBEEF) begin nFail++; $display("FAIL oor_rdata_held got=%h exp=deadbeef", rd); end
      access(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, cyc, st, err, rd, ok);
      nChecks++; if (rd !== 32'h11112222) begin nFail++; $display("FAIL oor_word0 got=%h exp=11112222", rd); end
      access(1'b0, 1'b1, 1'b1, 32'h20, 32'hFFFF0000, cyc, st, err, rd, ok);
      nChecks++; if (err !== 1'b1) begin nFail++; $display("FAIL conf_adderr got=%b exp=1", err); end
      nChecks++; if (st !== 1) begin nFail++; $display("FAIL conf_stalls got=%0d exp=1", st); end
      access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, cyc, st, err, rd, ok);
      nChecks++; if (rd !== 32'hCAFEF00D) begin nFail++; $display("FAIL conf_word8 got=%h exp=cafef00d", rd); end
   endtask

   task automatic test_reset_mid_store;
      int cyc, st; logic err; logic [31:0] rd; bit ok; int readies;
      readies = 0;
      @(negedge clk);
      MemWrite2 = 1'b1; Address2 = 32'h20; WriteData2 = 32'h12345678;
      @(negedge clk);
      MemWrite2 = 1'b0;
      #1;
      nChecks++; if (Stall2 !== 1'b1) begin nFail++; $display("FAIL rst_busy_stall got=%b exp=1", Stall2); end
      reset = 1'b1;
      #1;
      if (Ready2) readies++;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (Ready2) readies++;
         @(negedge clk);
      end
      nChecks++; if (readies !== 0) begin nFail++; $display("FAIL rst_ready got=%0d exp=0", readies); end
      nChecks++; if (ReadData2 !== 32'h0) begin nFail++; $display("FAIL rst_rdata got=%h exp=0", ReadData2); end
      access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, cyc, st, err, rd, ok);
      nChecks++; if (rd !== 32'hCAFEF00D) begin nFail++; $display("FAIL rst_word8 got=%h exp=cafef00d", rd); end
   endtask

   task automatic test_back_to_back;
      int cyc, st; logic err; logic [31:0] rd; bit ok;
      int pulses; int firstAt; int secondAt; logic [31:0] d0, d1;
      pulses = 0; firstAt = -1; secondAt = -1; d0 = '0; d1 = '0;
      access(1'b1, 1'b0, 1'b1, 32'h0, 32'hA5A50001, cyc, st, err, rd, ok);
      nChecks++; if (st !== 3) begin nFail++; $display("FAIL b2b_wr_stalls got=%0d exp=3", st); end
      access(1'b1, 1'b0, 1'b1, 32'h4, 32'h5A5A0004, cyc, st, err, rd, ok);
      @(negedge clk);
      MemRead3 = 1'b1; Address3 = 32'h0;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (Ready3) begin
            pulses++;
            if (pulses == 1) begin
               firstAt = c; d0 = ReadData3; Address3 = 32'h4;
            end else if (pulses == 2) begin
               secondAt = c; d1 = ReadData3; MemRead3 = 1'b0;
            end
         end
         @(negedge clk);
      end
      MemRead3 = 1'b0;
      nChecks++; if (pulses !== 2) begin nFail++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
      nChecks++; if (firstAt !== 3) begin nFail++; $display("FAIL b2b_first got=%0d exp=3", firstAt); end
      nChecks++; if (secondAt - firstAt !== 4) begin nFail++; $display("FAIL b2b_gap got=%0d exp=4", secondAt - firstAt); end
      nChecks++; if (d0 !== 32'hA5A50001) begin nFail++; $display("FAIL b2b_d0 got=%h exp=a5a50001", d0); end
      nChecks++; if (d1 !== 32'h5A5A0004) begin nFail++; $display("FAIL b2b_d1 got=%h exp=5a5a0004", d1); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_misaligned();
      test_range_conflict();
      test_reset_mid_store();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule

// File: doc/data_mem_unit.md
Name: data_mem_unit

Overview:
- Multi-cycle data-memory responder. It sits on the consumer side of the main controller's MemRead/MemWrite/MemtoReg interface.
- It accepts one load or store per request, holds the datapath with Stall for a configurable access latency, then returns ReadData with a one-cycle Ready pulse.
- It contains the word-organised data storage and checks alignment and range.

Parameters:
- DATA_WIDTH, 32, width of WriteData/ReadData and of each storage word.
- DEPTH, 64, number of storage words; power of two, at least 2.
- LATENCY, 2, total Stall cycles per valid access; at least 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- MemRead  input  1  load request from the controller.
- MemWrite  input  1  store request from the controller.
- Address  input  32  byte address from the ALU result.
- WriteData  input  DATA_WIDTH  store data (rs2).
- ReadData  output  DATA_WIDTH  registered load result.
- Stall  output  1  holds the PC and pipeline while an access is in flight.
- Ready  output  1  one-cycle pulse when an access completes.
- AddrError  output  1  one-cycle pulse, concurrent with Ready, when a request is rejected.

Behaviour:
- Reset and clocking
  - One clock; reset is synchronous and active-high.
  - On reset: FSM goes to IDLE, latency counter = 0, ReadData = 0, Ready = 0, AddrError = 0.
  - Stall is combinational and evaluates to 0 in IDLE with no request.
  - Storage contents are NOT cleared by reset.
- FSM states: IDLE, BUSY, DONE.
- IDLE
  - A request is MemRead | MemWrite.
  - Stall = request (combinational) in the request cycle.
  - On the clock edge with a request: capture Address, WriteData and op into internal registers.
  - Rejected request: next state DONE.
  - Accepted request with LATENCY=1: next state DONE.
  - Accepted request with LATENCY>1: next state BUSY, counter = LATENCY-1.
- Rejection rules
  - A request is rejected if Address[1:0] != 0 (misaligned).
  - A request is rejected if any Address bit above bit log2(DEPTH)+1 is set (out of range).
  - A request is rejected if MemRead and MemWrite are both 1.
- BUSY
  - Stall = 1; counter decrements each cycle.
  - When counter == 1 at the edge, go to DONE and commit the access at that same edge.
  - Read: ReadData <= mem[word index].
  - Write: mem[word index] <= captured WriteData.
  - Word index = captured Address[log2(DEPTH)+1:2].
- DONE (exactly one cycle)
  - Stall = 0, Ready = 1, AddrError = 1 only for a rejected request.
  - Request inputs are ignored in this cycle; they belong to the instruction being released.
  - Next state IDLE unconditionally.
- Rejected requests
  - No storage write.
  - ReadData <= 0 if the op was a read; ReadData unchanged otherwise.
  - Total Stall is 1 cycle (the request cycle only).
- Latency accounting
  - Valid access: Stall high for exactly LATENCY consecutive cycles (request cycle plus LATENCY-1 BUSY cycles), then the DONE cycle.
  - Request-to-Ready = LATENCY cycles.
  - Back-to-back requests: the earliest new acceptance is the cycle after DONE, giving a minimum of LATENCY+1 cycles per access.
- ReadData is held between accesses. It changes only on read completion, on rejected-read zeroing, or on reset. Writes do not modify ReadData.
- Inputs may change while in BUSY; only the captured copies are used.
- Reset mid-operation (BUSY or DONE)
  - Return to IDLE next edge with no commit.
  - A write in flight is dropped and storage is unchanged.
  - Ready and AddrError stay 0.
- Reset has priority over every other event in the same cycle.

Test Plan:
- LATENCY=2, reset then idle: Stall=0, Ready=0, AddrError=0, ReadData=0.
- Write then read:
  - Store 0xDEADBEEF to Address 0x10 -> Stall high 2 cycles, Ready pulse in cycle 3.
  - Load from 0x10 -> ReadData=0xDEADBEEF with Ready; Stall high exactly 2 cycles.
- Misaligned load at 0x13 -> 1 Stall cycle, then Ready=1, AddrError=1, ReadData=0. Storage is unchanged; a later load at 0x10 still returns 0xDEADBEEF.
- Out-of-range and conflicting requests:
  - Store to 0x100 (DEPTH=64) -> AddrError pulse, no write; word 0 is unchanged on a load from 0x0.
  - MemRead=MemWrite=1 at 0x20 -> AddrError pulse, no write.
- Reset mid-store: store 0x12345678 to 0x20, assert reset in the BUSY cycle -> IDLE, Ready never pulses; a load from 0x20 returns the prior value.
- Back-to-back loads from 0x0 and 0x4 with requests held high, LATENCY=3:
  - Ready pulses 4 cycles apart.
  - Request held during DONE is not double-accepted.
  - Each ReadData matches its word.
